id_decode_unit: RTL and testbench
=================================

# id_decode_unit

Combinational MIPS-I instruction decoder, next-instruction-address (branch/jump target) calculator and 32×32 register file, bundled as the decode-stage core. It sits inside the ID pipeline stage. Operand forwarding, branch comparison, syscall bubbling and the ID/EXE pipeline registers live in the enclosing stage and consume these outputs.

## Interface
- Parameters: none.
- CLK  in  1  clock; register-file writes occur on its rising edge.
- RESET  in  1  asynchronous, active-high; clears every register.
- Instr  in  32  instruction word being decoded.
- Instr_PC_Plus4  in  32  PC of Instr + 4.
- JumpRegValue  in  32  forwarded rs value, used as the JR/JALR target.
- RegA, RegB, RegC  in  5 each  read-port indices (rs, rt, destination).
- DataA, DataB, DataC  out  32 each  combinational read data.
- WriteReg  in  5  writeback index.
- WriteData  in  32  writeback data.
- Write  in  1  writeback enable.
- Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall  out  1 each  decode flags.
- ALUControl  out  6  ALU operation code.
- NextInstructionAddress  out  32  branch/jump target.

## Operation
- Decode is purely combinational on Instr.
- R-type (opcode 0):
  - RegDest=1, RegWrite=1.
  - ALU ops ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV.
  - JR: Jump=1, JumpRegister=1, RegWrite=0.
  - JALR: Jump=1, JumpRegister=1, Link=1, RegDest=1, RegWrite=1.
  - SYSCALL (funct 0x0C): Syscall=1, RegWrite=0.
- I-type ALU (ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI):
  - ALUSrc=1, RegWrite=1.
  - SignOrZero=0 for ANDI/ORI/XORI; 1 for all others.
- Loads LW/LB/LBU/LH/LHU and LL:
  - MemRead=1, ALUSrc=1, RegWrite=1, SignOrZero=1.
- Stores SW/SB/SH and SC:
  - MemWrite=1, ALUSrc=1, SignOrZero=1.
  - SC also sets RegWrite=1.
- LL and SC both assert Syscall=1, which forces the stage's flush sequence.
- Branches BEQ, BNE, BLEZ, BGTZ, and REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL:
  - Branch=1, SignOrZero=1.
  - The AL forms also set Link=1 and RegWrite=1.
- J: Jump=1.
- JAL: Jump=1, Link=1, RegWrite=1.
- Unknown opcode/funct: all flags 0 and ALUControl=0, i.e. a NOP.
- ALUControl uses package constants, one unique nonzero code per operation. Two codes are fixed: LL=6'b101000, SC=6'b110110.
- NextInstructionAddress:
  - If JumpRegister: JumpRegValue.
  - Else if Jump: {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00}.
  - Else: Instr_PC_Plus4 + (sign-extended Instr[15:0] << 2), with 32-bit wrap-around.
- Register file:
  - 32 entries × 32 bits, with three combinational read ports and one synchronous write port.
  - Register 0 always reads 0; writes to index 0 are ignored.
  - No internal write-to-read bypass; forwarding is done by the enclosing stage.

## Timing
- Decoder and target calculator have zero latency: outputs settle in the same cycle as inputs.
- Writes happen at the rising edge of CLK when Write=1. The new value appears on reads in the following cycle.
- Reading the register being written in the same cycle returns the old value.
- RESET asserted at any time, including mid-write, immediately zeroes all 32 registers. The write in that cycle is lost.
- Combinational outputs do not depend on RESET; they have no reset value.

## Structure
- Shared package holds:
  - opcode and funct constants;
  - ALUControl code constants (including LL/SC);
  - register-count and width constants.
- One natural sub-module, `id_regfile`, holding the storage and read/write ports.
- Decode and target logic stay in the top-level always_comb blocks.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse RESET → DataA for r5 reads 0. Write r0=0x1234 → DataA for r0 reads 0.
- Same-cycle read/write: write r7=0xA5A5A5A5 with RegA=7 → old value that cycle, 0xA5A5A5A5 the next cycle.
- ADDI r2,r1,-1 (0x2022FFFF) → ALUSrc=1, RegWrite=1, SignOrZero=1, RegDest=0, Jump=0, Branch=0.
- BEQ at PC+4=0x00400004 with imm=0xFFFF → Branch=1, NextInstructionAddress=0x00400000.
- JAL 0x0C100010 with PC+4=0x00400008 → Jump=1, Link=1, target=0x00400040.
- JR with JumpRegValue=0x00400100 → JumpRegister=1, target=0x00400100.
- SYSCALL 0x0000000C → Syscall=1.
- LL → Syscall=1, MemRead=1, ALUControl=6'b101000.

Source files
------------

// File: rtl/id_decode_unit_pkg.sv
// Shared constants for the ID-stage decoder: opcodes, funct/REGIMM codes,
// ALU operation codes and register-file geometry.
package id_decode_unit_pkg;

  localparam int REG_W     = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_LL     = 6'h30;
  localparam logic [5:0] OP_SC     = 6'h38;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [4:0] RI_BLTZ   = 5'h00;
  localparam logic [4:0] RI_BGEZ   = 5'h01;
  localparam logic [4:0] RI_BLTZAL = 5'h10;
  localparam logic [4:0] RI_BGEZAL = 5'h11;

  // Immediate ALU forms share the code of their register-register counterpart.
  localparam logic [5:0] ALU_ADD  = 6'd1;
  localparam logic [5:0] ALU_ADDU = 6'd2;
  localparam logic [5:0] ALU_SUB  = 6'd3;
  localparam logic [5:0] ALU_SUBU = 6'd4;
  localparam logic [5:0] ALU_AND  = 6'd5;
  localparam logic [5:0] ALU_OR   = 6'd6;
  localparam logic [5:0] ALU_XOR  = 6'd7;
  localparam logic [5:0] ALU_NOR  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;
  localparam logic [5:0] ALU_SLTU = 6'd10;
  localparam logic [5:0] ALU_SLL  = 6'd11;
  localparam logic [5:0] ALU_SRL  = 6'd12;
  localparam logic [5:0] ALU_SRA  = 6'd13;
  localparam logic [5:0] ALU_SLLV = 6'd14;
  localparam logic [5:0] ALU_SRLV = 6'd15;
  localparam logic [5:0] ALU_SRAV = 6'd16;
  localparam logic [5:0] ALU_LUI  = 6'd17;
  localparam logic [5:0] ALU_LW   = 6'd18;
  localparam logic [5:0] ALU_LB   = 6'd19;
  localparam logic [5:0] ALU_LBU  = 6'd20;
  localparam logic [5:0] ALU_LH   = 6'd21;
  localparam logic [5:0] ALU_LHU  = 6'd22;
  localparam logic [5:0] ALU_SW   = 6'd23;
  localparam logic [5:0] ALU_SB   = 6'd24;
  localparam logic [5:0] ALU_SH   = 6'd25;
  localparam logic [5:0] ALU_BEQ  = 6'd26;
  localparam logic [5:0] ALU_BNE  = 6'd27;
  localparam logic [5:0] ALU_BLEZ = 6'd28;
  localparam logic [5:0] ALU_BGTZ = 6'd29;
  localparam logic [5:0] ALU_BLTZ = 6'd30;
  localparam logic [5:0] ALU_BGEZ = 6'd31;
  localparam logic [5:0] ALU_LL   = 6'b101000;
  localparam logic [5:0] ALU_SC   = 6'b110110;

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file: three combinational read ports, one write port,
// r0 hardwired to zero, no write-to-read bypass.
module id_regfile
  import id_decode_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] raddr_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  input  logic [REG_IDX_W-1:0] raddr_c,
  output logic [REG_W-1:0]     rdata_a,
  output logic [REG_W-1:0]     rdata_b,
  output logic [REG_W-1:0]     rdata_c,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [REG_W-1:0]     wdata,
  input  logic                 we
);

  logic [REG_W-1:0] regs_q [NUM_REGS];
  logic [REG_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 is never written, so reading the stored entry already yields zero.
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign rdata_c = regs_q[raddr_c];

endmodule

// File: rtl/id_decode_unit.sv
// MIPS-I decode-stage core: instruction decoder, branch/jump target
// calculator and the register file.
module id_decode_unit
  import id_decode_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] Instr_PC_Plus4,
  input  logic [31:0] JumpRegValue,
  input  logic [4:0]  RegA,
  input  logic [4:0]  RegB,
  input  logic [4:0]  RegC,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [31:0] DataC,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic        Write,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl,
  output logic [31:0] NextInstructionAddress
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [31:0] branch_off;

  assign opcode     = Instr[31:26];
  assign funct      = Instr[5:0];
  assign rt         = Instr[20:16];
  assign branch_off = {{14{Instr[15]}}, Instr[15:0], 2'b00};

  id_regfile u_regfile (
    .clk     (CLK),
    .rst     (RESET),
    .raddr_a (RegA),
    .raddr_b (RegB),
    .raddr_c (RegC),
    .rdata_a (DataA),
    .rdata_b (DataB),
    .rdata_c (DataC),
    .waddr   (WriteReg),
    .wdata   (WriteData),
    .we      (Write)
  );

  always_comb begin
    Link         = 1'b0;
    RegDest      = 1'b0;
    Jump         = 1'b0;
    Branch       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    ALUSrc       = 1'b0;
    RegWrite     = 1'b0;
    JumpRegister = 1'b0;
    SignOrZero   = 1'b0;
    Syscall      = 1'b0;
    ALUControl   = '0;
    case (opcode)
      OP_RTYPE: begin
        RegDest  = 1'b1;
        RegWrite = 1'b1;
        case (funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_ADDU: ALUControl = ALU_ADDU;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_SUBU: ALUControl = ALU_SUBU;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_XOR:  ALUControl = ALU_XOR;
          FN_NOR:  ALUControl = ALU_NOR;
          FN_SLT:  ALUControl = ALU_SLT;
          FN_SLTU: ALUControl = ALU_SLTU;
          FN_SLL:  ALUControl = ALU_SLL;
          FN_SRL:  ALUControl = ALU_SRL;
          FN_SRA:  ALUControl = ALU_SRA;
          FN_SLLV: ALUControl = ALU_SLLV;
          FN_SRLV: ALUControl = ALU_SRLV;
          FN_SRAV: ALUControl = ALU_SRAV;
          FN_JR: begin
            Jump         = 1'b1;
            JumpRegister = 1'b1;
            RegWrite     = 1'b0;
          end
          FN_JALR: begin
            Jump         = 1'b1;
            JumpRegister = 1'b1;
            Link         = 1'b1;
          end
          FN_SYSCALL: begin
            Syscall  = 1'b1;
            RegWrite = 1'b0;
          end
          default: begin
            RegDest  = 1'b0;
            RegWrite = 1'b0;
          end
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RI_BLTZ, RI_BLTZAL: begin
            Branch     = 1'b1;
            SignOrZero = 1'b1;
            ALUControl = ALU_BLTZ;
            Link       = (rt == RI_BLTZAL);
            RegWrite   = (rt == RI_BLTZAL);
          end
          RI_BGEZ, RI_BGEZAL: begin
            Branch     = 1'b1;
            SignOrZero = 1'b1;
            ALUControl = ALU_BGEZ;
            Link       = (rt == RI_BGEZAL);
            RegWrite   = (rt == RI_BGEZAL);
          end
          default: ;
        endcase
      end
      OP_J:   Jump = 1'b1;
      OP_JAL: begin
        Jump     = 1'b1;
        Link     = 1'b1;
        RegWrite = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        Branch     = 1'b1;
        SignOrZero = 1'b1;
        case (opcode)
          OP_BEQ:  ALUControl = ALU_BEQ;
          OP_BNE:  ALUControl = ALU_BNE;
          OP_BLEZ: ALUControl = ALU_BLEZ;
          default: ALUControl = ALU_BGTZ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = !(opcode inside {OP_ANDI, OP_ORI, OP_XORI});
        case (opcode)
          OP_ADDI:  ALUControl = ALU_ADD;
          OP_ADDIU: ALUControl = ALU_ADDU;
          OP_SLTI:  ALUControl = ALU_SLT;
          OP_SLTIU: ALUControl = ALU_SLTU;
          OP_ANDI:  ALUControl = ALU_AND;
          OP_ORI:   ALUControl = ALU_OR;
          OP_XORI:  ALUControl = ALU_XOR;
          default:  ALUControl = ALU_LUI;
        endcase
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LL: begin
        MemRead    = 1'b1;
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = 1'b1;
        // LL/SC raise Syscall so the stage flushes around the atomic access.
        Syscall    = (opcode == OP_LL);
        case (opcode)
          OP_LW:   ALUControl = ALU_LW;
          OP_LB:   ALUControl = ALU_LB;
          OP_LBU:  ALUControl = ALU_LBU;
          OP_LH:   ALUControl = ALU_LH;
          OP_LHU:  ALUControl = ALU_LHU;
          default: ALUControl = ALU_LL;
        endcase
      end
      OP_SW, OP_SB, OP_SH, OP_SC: begin
        MemWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        RegWrite   = (opcode == OP_SC);
        Syscall    = (opcode == OP_SC);
        case (opcode)
          OP_SW:   ALUControl = ALU_SW;
          OP_SB:   ALUControl = ALU_SB;
          OP_SH:   ALUControl = ALU_SH;
          default: ALUControl = ALU_SC;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    if (JumpRegister)  NextInstructionAddress = JumpRegValue;
    else if (Jump)     NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
    else               NextInstructionAddress = Instr_PC_Plus4 + branch_off;
  end

endmodule

// File: tb/tb_id_decode_unit.sv
// Self-checking bench for id_decode_unit: decode/target vector table plus
// register-file sequences, all through an expected-value queue.
module tb_id_decode_unit;
  import id_decode_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr, Instr_PC_Plus4, JumpRegValue;
  logic [4:0]  RegA, RegB, RegC, WriteReg;
  logic [31:0] DataA, DataB, DataC, WriteData;
  logic        Write;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc;
  logic        RegWrite, JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;
  logic [31:0] NextInstructionAddress;

  id_decode_unit dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .Instr_PC_Plus4(Instr_PC_Plus4),
    .JumpRegValue(JumpRegValue), .RegA(RegA), .RegB(RegB), .RegC(RegC),
    .DataA(DataA), .DataB(DataB), .DataC(DataC), .WriteReg(WriteReg),
    .WriteData(WriteData), .Write(Write), .Link(Link), .RegDest(RegDest),
    .Jump(Jump), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .JumpRegister(JumpRegister),
    .SignOrZero(SignOrZero), .Syscall(Syscall), .ALUControl(ALUControl),
    .NextInstructionAddress(NextInstructionAddress)
  );

  always #5 CLK = ~CLK;

  localparam logic [10:0] F_LINK = 11'h400, F_RDST = 11'h200, F_JMP = 11'h100,
                          F_BR   = 11'h080, F_MRD  = 11'h040, F_MWR = 11'h020,
                          F_ASRC = 11'h010, F_RWR  = 11'h008, F_JR  = 11'h004,
                          F_SOZ  = 11'h002, F_SYS  = 11'h001;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] jrv;
    logic [10:0] flags;
    logic [5:0]  alu;
    logic [31:0] nia;
  } vec_t;

  typedef struct {
    logic [10:0] flags;
    logic [5:0]  alu;
    logic [31:0] nia;
  } exp_t;

  vec_t        vecs[17];
  exp_t        exp_q[$];
  logic [31:0] data_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [10:0] act_flags;
  assign act_flags = {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
                      RegWrite, JumpRegister, SignOrZero, Syscall};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [31:0] act);
    if (data_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%08h expected entry", name, act);
    end else begin
      check(name, act, data_q.pop_front());
    end
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    @(negedge CLK);
    WriteReg  = idx;
    WriteData = val;
    Write     = 1'b1;
    @(posedge CLK);
    #1;
    Write = 1'b0;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{"addi",    32'h2022FFFF, 32'h00400000, 32'h0, F_ASRC|F_RWR|F_SOZ,              ALU_ADD,  32'h003FFFFC};
    vecs[1]  = '{"beq",     32'h1022FFFF, 32'h00400004, 32'h0, F_BR|F_SOZ,                      ALU_BEQ,  32'h00400000};
    vecs[2]  = '{"jal",     32'h0C100010, 32'h00400008, 32'h0, F_JMP|F_LINK|F_RWR,              6'd0,     32'h00400040};
    vecs[3]  = '{"jr",      32'h00200008, 32'h00400000, 32'h00400100, F_JMP|F_JR|F_RDST,        6'd0,     32'h00400100};
    vecs[4]  = '{"syscall", 32'h0000000C, 32'h00001000, 32'h0, F_SYS|F_RDST,                    6'd0,     32'h00001030};
    vecs[5]  = '{"ll",      32'hC0220004, 32'h00000100, 32'h0, F_MRD|F_ASRC|F_RWR|F_SOZ|F_SYS,  6'b101000, 32'h00000110};
    vecs[6]  = '{"sc",      32'hE0220008, 32'h00000200, 32'h0, F_MWR|F_ASRC|F_RWR|F_SOZ|F_SYS,  6'b110110, 32'h00000220};
    vecs[7]  = '{"ori",     32'h342200FF, 32'h00000000, 32'h0, F_ASRC|F_RWR,                    ALU_OR,   32'h000003FC};
    vecs[8]  = '{"add",     32'h00221820, 32'h00000000, 32'h0, F_RDST|F_RWR,                    ALU_ADD,  32'h00006080};
    vecs[9]  = '{"bltzal",  32'h04300003, 32'h00001000, 32'h0, F_BR|F_SOZ|F_LINK|F_RWR,         ALU_BLTZ, 32'h0000100C};
    vecs[10] = '{"bad_op",  32'hFC000000, 32'h12345678, 32'h0, 11'h000,                         6'd0,     32'h12345678};
    vecs[11] = '{"bad_fn",  32'h00000001, 32'hFFFFFFFC, 32'h0, 11'h000,                         6'd0,     32'h00000000};
    vecs[12] = '{"jalr",    32'h00201009, 32'h00000000, 32'hDEADBEE0, F_JMP|F_JR|F_LINK|F_RDST|F_RWR, 6'd0, 32'hDEADBEE0};
    vecs[13] = '{"j",       32'h08000001, 32'hA0000000, 32'h0, F_JMP,                           6'd0,     32'hA0000004};
    vecs[14] = '{"sw",      32'hAC220010, 32'h00000000, 32'h0, F_MWR|F_ASRC|F_SOZ,              ALU_SW,   32'h00000040};
    vecs[15] = '{"lui",     32'h3C011234, 32'h00000000, 32'h0, F_ASRC|F_RWR|F_SOZ,              ALU_LUI,  32'h000048D0};
    vecs[16] = '{"bne_min", 32'h14228000, 32'h00020000, 32'h0, F_BR|F_SOZ,                      ALU_BNE,  32'h00000000};

    RESET = 1'b1;
    Instr = '0; Instr_PC_Plus4 = '0; JumpRegValue = '0;
    RegA = '0; RegB = '0; RegC = '0;
    WriteReg = '0; WriteData = '0; Write = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    RegA = 5'd5;
    data_q.push_back(32'h0);
    #1 check_data("reset_r5", DataA);

    write_reg(5'd5, 32'hDEADBEEF);
    data_q.push_back(32'hDEADBEEF);
    check_data("write_r5", DataA);
    RESET = 1'b1;
    #1 RESET = 1'b0;
    data_q.push_back(32'h0);
    #1 check_data("pulse_reset_r5", DataA);

    RegA = 5'd0;
    write_reg(5'd0, 32'h00001234);
    data_q.push_back(32'h0);
    check_data("r0_write_ignored", DataA);

    @(negedge CLK);
    RegA = 5'd7; RegB = 5'd7; RegC = 5'd7;
    WriteReg = 5'd7; WriteData = 32'hA5A5A5A5; Write = 1'b1;
    data_q.push_back(32'h0);
    #1 check_data("same_cycle_old", DataA);
    @(posedge CLK);
    #1 Write = 1'b0;
    data_q.push_back(32'hA5A5A5A5);
    data_q.push_back(32'hA5A5A5A5);
    data_q.push_back(32'hA5A5A5A5);
    check_data("next_cycle_a", DataA);
    check_data("next_cycle_b", DataB);
    check_data("next_cycle_c", DataC);

    @(negedge CLK);
    WriteReg = 5'd9; WriteData = 32'h13572468; Write = 1'b1;
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    Write = 1'b0;
    RegA = 5'd9; RegB = 5'd7;
    data_q.push_back(32'h0);
    data_q.push_back(32'h0);
    #1 check_data("midwrite_lost_r9", DataA);
    check_data("midwrite_clears_r7", DataB);

    for (int i = 0; i < 17; i++) begin
      Instr          = vecs[i].instr;
      Instr_PC_Plus4 = vecs[i].pc4;
      JumpRegValue   = vecs[i].jrv;
      exp_q.push_back('{vecs[i].flags, vecs[i].alu, vecs[i].nia});
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: decode scoreboard empty", vecs[i].name);
      end else begin
        e = exp_q.pop_front();
        check({vecs[i].name, "_flags"}, {21'd0, act_flags}, {21'd0, e.flags});
        check({vecs[i].name, "_alu"},   {26'd0, ALUControl}, {26'd0, e.alu});
        check({vecs[i].name, "_nia"},   NextInstructionAddress, e.nia);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
